// File: rtl/gbus_pkg.sv
// Shared bus packet definitions: field widths, the packed packet layout and the idle sentinel.
package gbus_pkg;

    localparam int BUS_DATA_WIDTH       = 32;
    localparam int HEAD_SRAM_BIAS_WIDTH = 2;
    localparam int BUS_CORE_ADDR_WIDTH  = 4;
    localparam int BUS_CMEM_ADDR_WIDTH  = 13;
    localparam int BUS_PACKET_WIDTH     = BUS_DATA_WIDTH + HEAD_SRAM_BIAS_WIDTH
                                        + BUS_CORE_ADDR_WIDTH + BUS_CMEM_ADDR_WIDTH;

    typedef struct packed {
        logic [BUS_DATA_WIDTH-1:0]       data;
        logic [HEAD_SRAM_BIAS_WIDTH-1:0] head_bias;
        logic [BUS_CORE_ADDR_WIDTH-1:0]  core_addr;
        logic [BUS_CMEM_ADDR_WIDTH-1:0]  cmem_addr;
    } bus_packet_t;

    localparam logic [BUS_CORE_ADDR_WIDTH-1:0] IDLE_CORE_ADDR = 4'hF;

    // An all-ones core address never names a real core, so the bus controller reads it as "no packet".
    localparam bus_packet_t IDLE_PACKET = '{
        data:      '0,
        head_bias: '0,
        core_addr: IDLE_CORE_ADDR,
        cmem_addr: '0
    };

endpackage

// File: rtl/gbus_sync_fifo.sv
// Single-clock FIFO with separate occupancy counter; a push into a full queue is dropped even when a pop coincides.
module gbus_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 51,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bus_requester.sv
// Queues core packets and presents one per arbiter grant for exactly one cycle, idle sentinel otherwise.
// Optional BUS_REQUESTER_PKT_CNT_EN adds a 16-bit wrapping count of presented packets.
module bus_requester
    import gbus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [BUS_DATA_WIDTH-1:0]       wr_data,
    input  logic [HEAD_SRAM_BIAS_WIDTH-1:0] wr_head_bias,
    input  logic [BUS_CORE_ADDR_WIDTH-1:0]  wr_core_addr,
    input  logic [BUS_CMEM_ADDR_WIDTH-1:0]  wr_cmem_addr,
    output logic                            full,
    output logic                            empty,
    output logic                            overflow,
    output logic                            bus_req,
    input  logic                            bus_grant,
`ifdef BUS_REQUESTER_PKT_CNT_EN
    output logic [15:0]                     pkt_cnt,
`endif
    output bus_packet_t                     out_bus_packet
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_packet_t in_pkt;
    bus_packet_t head_pkt;
    logic        pop;
    logic [CW-1:0] count;
    logic        count_unused;

    assign in_pkt = '{
        data:      wr_data,
        head_bias: wr_head_bias,
        core_addr: wr_core_addr,
        cmem_addr: wr_cmem_addr
    };

    assign pop          = bus_grant && !empty;
    assign bus_req      = !empty;
    assign count_unused = ^count;

    gbus_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BUS_PACKET_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .pop   (pop),
        .din   (in_pkt),
        .dout  (head_pkt),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Presentation register: the head appears the cycle after a qualifying grant, else the sentinel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bus_packet <= IDLE_PACKET;
        end else if (pop) begin
            out_bus_packet <= head_pkt;
        end else begin
            out_bus_packet <= IDLE_PACKET;
        end
    end

    // Sticky until reset: any write attempted while full is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

`ifdef BUS_REQUESTER_PKT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (pop) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_requester.sv
// Bench for bus_requester: scripted vector table, mid-cycle reset sequence, randomized run against a queue model.
module tb_bus_requester;

    localparam int D = 4;
    localparam logic [50:0] IDLE = {32'h0, 2'h0, 4'hF, 13'h0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_head_bias = '0;
    logic [3:0]  wr_core_addr = '0;
    logic [12:0] wr_cmem_addr = '0;
    logic        bus_grant = 1'b0;
    logic        full, empty, overflow, bus_req;
    logic [50:0] out_bus_packet;
`ifdef BUS_REQUESTER_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bus_requester #(.FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_head_bias   (wr_head_bias),
        .wr_core_addr   (wr_core_addr),
        .wr_cmem_addr   (wr_cmem_addr),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow),
        .bus_req        (bus_req),
        .bus_grant      (bus_grant),
`ifdef BUS_REQUESTER_PKT_CNT_EN
        .pkt_cnt        (pkt_cnt),
`endif
        .out_bus_packet (out_bus_packet)
    );

    typedef struct {
        logic        w;
        logic [31:0] d;
        logic [1:0]  b;
        logic [3:0]  c;
        logic [12:0] m;
        logic        g;
        logic [50:0] e_out;
        logic        e_full, e_empty, e_ovf, e_req;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [50:0] pk(logic [31:0] d, logic [1:0] b, logic [3:0] c, logic [12:0] m);
        return {d, b, c, m};
    endfunction

    function automatic vec_t mk(logic w, logic [31:0] d, logic [1:0] b, logic [3:0] c, logic [12:0] m,
                                logic g, logic [50:0] eo, logic ef, logic ee, logic ev, logic er);
        vec_t v;
        v.w = w; v.d = d; v.b = b; v.c = c; v.m = m; v.g = g;
        v.e_out = eo; v.e_full = ef; v.e_empty = ee; v.e_ovf = ev; v.e_req = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic w, input logic [31:0] d, input logic [1:0] b, input logic [3:0] c,
                        input logic [12:0] m, input logic g);
        wr_en = w; wr_data = d; wr_head_bias = b; wr_core_addr = c; wr_cmem_addr = m; bus_grant = g;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; bus_grant = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Behavioural reference for the randomized phase
    logic [50:0] mq[$];
    logic        m_ovf;
    logic [15:0] m_cnt;

    initial begin
        logic [50:0] e_out;
        logic [50:0] p;
        int pw[6] = '{80, 50, 30, 90, 60, 20};
        int pg[6] = '{20, 50, 80, 30, 60, 90};

        // Scripted vectors
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, IDLE, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h11, 0, 2, 5, 0, IDLE, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, pk(32'h11, 0, 2, 5), 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, IDLE, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 32'hA0 + i, 2'(i), 4'(i), 13'(100 + i), 0, IDLE, i == 3, 0, 0, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, pk(32'hA0 + i, 2'(i), 4'(i), 13'(100 + i)), 0, i == 3, 0, i != 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, IDLE, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 32'hB0 + i, 2'(3 - i), 4'(8 + i), 13'h1F00 + 13'(i), 0, IDLE, i == 3, 0, 0, 1));
        tbl.push_back(mk(1, 32'hB4, 0, 12, 13'h1F04, 1, pk(32'hB0, 3, 8, 13'h1F00), 0, 0, 1, 1));
        for (int i = 1; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, pk(32'hB0 + i, 2'(3 - i), 4'(8 + i), 13'h1F00 + 13'(i)),
                             0, i == 3, 1, i != 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, IDLE, 0, 1, 1, 0));

        do_reset();
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_out", 64'(out_bus_packet), 64'(IDLE));
`ifdef BUS_REQUESTER_PKT_CNT_EN
        chk("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        foreach (tbl[k]) begin
            step(tbl[k].w, tbl[k].d, tbl[k].b, tbl[k].c, tbl[k].m, tbl[k].g);
            chk($sformatf("tbl%0d_out", k), 64'(out_bus_packet), 64'(tbl[k].e_out));
            chk($sformatf("tbl%0d_full", k), 64'(full), 64'(tbl[k].e_full));
            chk($sformatf("tbl%0d_empty", k), 64'(empty), 64'(tbl[k].e_empty));
            chk($sformatf("tbl%0d_ovf", k), 64'(overflow), 64'(tbl[k].e_ovf));
            chk($sformatf("tbl%0d_req", k), 64'(bus_req), 64'(tbl[k].e_req));
        end

        // Asynchronous reset mid-cycle with 3 entries queued and a packet on the bus
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'hC0 + i, 1, 4'(i), 13'(i), 0);
        step(0, 0, 0, 0, 0, 1);
        chk("mid_pre_out", 64'(out_bus_packet), 64'(pk(32'hC0, 1, 0, 0)));
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_req", 64'(bus_req), 64'd0);
        chk("mid_rst_out", 64'(out_bus_packet), 64'(IDLE));
        chk("mid_rst_full", 64'(full), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        chk("post_rst_out", 64'(out_bus_packet), 64'(IDLE));
        step(0, 0, 0, 0, 0, 0);
        chk("post_rst_out2", 64'(out_bus_packet), 64'(IDLE));
        chk("post_rst_empty", 64'(empty), 64'd1);

        // Randomized run against queue model
        do_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = '0;
        for (int blk = 0; blk < 6; blk++) begin
            for (int n = 0; n < 400; n++) begin
                logic w, g;
                logic [31:0] d;
                logic [1:0] b;
                logic [3:0] c;
                logic [12:0] m;
                int sz;
                w = ($urandom_range(99) < 32'(pw[blk]));
                g = ($urandom_range(99) < 32'(pg[blk]));
                d = $urandom; b = 2'($urandom); c = 4'($urandom); m = 13'($urandom);
                sz = mq.size();
                e_out = IDLE;
                if (g && sz > 0) begin
                    e_out = mq.pop_front();
                    m_cnt++;
                end
                if (w && sz < D) mq.push_back(pk(d, b, c, m));
                if (w && sz == D) m_ovf = 1'b1;
                step(w, d, b, c, m, g);
                chk("rnd_out", 64'(out_bus_packet), 64'(e_out));
                chk("rnd_full", 64'(full), 64'(mq.size() == D));
                chk("rnd_empty", 64'(empty), 64'(mq.size() == 0));
                chk("rnd_req", 64'(bus_req), 64'(mq.size() != 0));
                chk("rnd_ovf", 64'(overflow), 64'(m_ovf));
`ifdef BUS_REQUESTER_PKT_CNT_EN
                chk("rnd_pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
`endif
            end
        end

`ifdef BUS_REQUESTER_PKT_CNT_EN
        // 65537 grants that each pop an entry: counter wraps past 16'hFFFF to 1
        do_reset();
        p = pk(32'h5, 0, 1, 1);
        step(1, 32'h5, 0, 1, 1, 1);
        for (int i = 0; i < 65536; i++) step(1, 32'h5, 0, 1, 1, 1);
        chk("wrap_at_65536", 64'(pkt_cnt), 64'd0);
        step(1, 32'h5, 0, 1, 1, 1);
        chk("wrap_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("wrap_out", 64'(out_bus_packet), 64'(p));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bus_requester.md
BUS_REQUESTER -- requirements
Module: bus_requester

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set packet queue depth; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 wr_en  input  1  enqueue request from the core.
REQ-005 wr_data  input  32  packet data field.
REQ-006 wr_head_bias  input  2  head SRAM bias field.
REQ-007 wr_core_addr  input  4  destination core address field.
REQ-008 wr_cmem_addr  input  13  destination core-memory address field.
REQ-009 full  output  1  queue holds FIFO_DEPTH entries.
REQ-010 empty  output  1  queue holds zero entries.
REQ-011 overflow  output  1  sticky flag: a write was dropped.
REQ-012 bus_req  output  1  request to the bus arbiter.
REQ-013 bus_grant  input  1  this requester's grant bit from the arbiter.
REQ-014 out_bus_packet  output  51  packet to bus_controller, laid out as {data[50:19], head_bias[18:17], core_addr[16:13], cmem_addr[12:0]}.

Function
REQ-015 bus_req SHALL equal !empty, combinationally from registered state.
REQ-016 When bus_grant=1 and empty=0 at edge t, the block SHALL pop the queue head and load it into out_bus_packet, valid for exactly cycle t+1.
REQ-017 In every cycle not following a qualifying grant, out_bus_packet SHALL be the idle sentinel: all bits 0 except core_addr = 4'hF.
REQ-018 bus_grant while empty SHALL be ignored: no pop, no state change, out_bus_packet stays idle.
REQ-019 Back-to-back grants SHALL pop one entry per cycle, so out_bus_packet carries consecutive entries in consecutive cycles in FIFO order.
REQ-020 wr_en with full=0 SHALL enqueue {wr_data, wr_head_bias, wr_core_addr, wr_cmem_addr} at the edge.
REQ-021 wr_en with full=1 SHALL drop the write, even if a pop occurs in the same cycle, and SHALL set overflow.
REQ-022 A simultaneous accepted write and pop SHALL leave the occupancy unchanged.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy is a separate counter of width $clog2(FIFO_DEPTH)+1.
REQ-024 overflow SHALL clear only on reset.

Reset
REQ-025 On rst_n=0, regardless of cycle position, the block SHALL immediately set pointers and count to 0, empty=1, full=0, overflow=0, bus_req=0, and out_bus_packet to the idle sentinel.
REQ-026 Queue contents SHALL be discarded by reset; an in-flight presentation is abandoned.

Configuration
REQ-027 With BUS_REQUESTER_PKT_CNT_EN defined, the block SHALL add output pkt_cnt [15:0], incrementing on each qualifying grant, wrapping 16'hFFFF to 0, and reset to 0.
REQ-028 Without BUS_REQUESTER_PKT_CNT_EN, neither the port nor the counter SHALL exist, and behaviour is otherwise identical.

Structure
REQ-029 The widths (BUS_DATA_WIDTH=32, HEAD_SRAM_BIAS_WIDTH=2, BUS_CORE_ADDR_WIDTH=4, BUS_CMEM_ADDR_WIDTH=13), the packed bus packet typedef and the idle core-address constant SHALL live in shared package gbus_pkg.
REQ-030 Queue storage SHALL be one sub-module, gbus_sync_fifo (push, pop, full, empty, count), instantiated once.

Verification
REQ-031 Reset, then write A (data 32'h11, core 2, cmem 5); grant at the next cycle -> bus_req=1 until the grant, A presented the cycle after the grant, idle sentinel the cycle after that, empty=1.
REQ-032 Write 4 packets P0..P3 with grant held high -> P0..P3 presented on 4 consecutive cycles, then the idle sentinel, bus_req=0.
REQ-033 Fill with 4 entries, then a 5th write concurrent with a grant -> 5th dropped, overflow=1 and sticky, only P0..P3 ever emitted.
REQ-034 Grant pulse while empty -> out_bus_packet stays idle (core_addr 4'hF), no count change.
REQ-035 Assert rst_n=0 mid-stream with 3 entries queued -> empty=1, bus_req=0, idle output at once; a later grant emits nothing.
REQ-036 With BUS_REQUESTER_PKT_CNT_EN, preload pkt_cnt by issuing 65536 grants then one more -> pkt_cnt wraps to 1.
